// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate clock enable, h/v counters and registered
// sync/blanking decode aligned with the counts, plus a frame-start strobe.
module vga_timing_gen #(
   parameter int CLK_DIV     = 4,
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_VIS_START = 144,
   parameter int H_VIS_END   = 784,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_VIS_START = 35,
   parameter int V_VIS_END   = 515
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       bright,
   output logic       hSync,
   output logic       vSync,
   output logic       pixel_ce,
   output logic       frame_start
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   logic [DW-1:0] r_div_cnt;
   logic [9:0]    r_h_cnt;
   logic [9:0]    r_v_cnt;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_bright;
   logic          r_frame_start;

   logic          w_pixel_ce;
   logic          w_h_last;
   logic          w_v_last;
   logic          w_line_end;
   logic [9:0]    w_h_nxt;
   logic [9:0]    w_v_nxt;
   logic          w_hsync_nxt;
   logic          w_vsync_nxt;
   logic          w_bright_nxt;

   assign w_pixel_ce = (r_div_cnt == DIV_LAST);
   assign w_h_last   = (r_h_cnt == H_LAST);
   assign w_v_last   = (r_v_cnt == V_LAST);
   assign w_line_end = w_pixel_ce && w_h_last;

   always_comb begin
      w_h_nxt = r_h_cnt;
      w_v_nxt = r_v_cnt;
      if (w_pixel_ce) begin
         w_h_nxt = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
      end
      if (w_line_end) begin
         w_v_nxt = w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end
   end

   // Decode from the next-state counts so the registered outputs line up
   // with the counts they describe on the same edge.
   assign w_hsync_nxt  = !(w_h_nxt < 10'(H_SYNC));
   assign w_vsync_nxt  = !(w_v_nxt < 10'(V_SYNC));
   assign w_bright_nxt = (w_h_nxt >= 10'(H_VIS_START)) && (w_h_nxt < 10'(H_VIS_END)) &&
                         (w_v_nxt >= 10'(V_VIS_START)) && (w_v_nxt < 10'(V_VIS_END));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt     <= '0;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_hsync       <= 1'b0;
         r_vsync       <= 1'b0;
         r_bright      <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_div_cnt     <= w_pixel_ce ? '0 : r_div_cnt + 1'b1;
         r_h_cnt       <= w_h_nxt;
         r_v_cnt       <= w_v_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_bright      <= w_bright_nxt;
         r_frame_start <= w_line_end && w_v_last;
      end
   end

   assign hCount      = r_h_cnt;
   assign vCount      = r_v_cnt;
   assign hSync       = r_hsync;
   assign vSync       = r_vsync;
   assign bright      = r_bright;
   assign pixel_ce    = w_pixel_ce;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance for line timing and
// a shrunken-raster instance (40x20 pixels) for window, frame and reset checks.
module tb_vga_timing_gen;

   logic       clk;
   logic       rst_n;
   logic [9:0] a_h, a_v, b_h, b_v;
   logic       a_bright, a_hs, a_vs, a_ce, a_fs;
   logic       b_bright, b_hs, b_vs, b_ce, b_fs;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   vga_timing_gen u_a (
      .clk(clk), .rst_n(rst_n), .hCount(a_h), .vCount(a_v), .bright(a_bright),
      .hSync(a_hs), .vSync(a_vs), .pixel_ce(a_ce), .frame_start(a_fs)
   );

   vga_timing_gen #(
      .CLK_DIV(4), .H_TOTAL(40), .H_SYNC(6), .H_VIS_START(10), .H_VIS_END(34),
      .V_TOTAL(20), .V_SYNC(2), .V_VIS_START(4), .V_VIS_END(18)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .hCount(b_h), .vCount(b_v), .bright(b_bright),
      .hSync(b_hs), .vSync(b_vs), .pixel_ce(b_ce), .frame_start(b_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
   endtask

   task automatic go_to(input int target);
      if (target > cyc) step(target - cyc);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a"}, {7'd0, a_h, a_v, a_bright, a_hs, a_vs, a_ce, a_fs}, 32'd0);
      chk({tag, "_b"}, {7'd0, b_h, b_v, b_bright, b_hs, b_vs, b_ce, b_fs}, 32'd0);
   endtask

   task automatic release_seq(input string tag);
      rst_n = 1'b1;
      cyc   = 0;
      step(1);
      chk({tag, "_div1_ce"}, {31'd0, a_ce}, 32'd0);
      chk({tag, "_div1_h"},  {22'd0, a_h}, 32'd0);
      step(2);
      chk({tag, "_e3_ce_a"}, {31'd0, a_ce}, 32'd1);
      chk({tag, "_e3_ce_b"}, {31'd0, b_ce}, 32'd1);
      chk({tag, "_e3_h"},    {22'd0, a_h}, 32'd0);
      chk({tag, "_e3_fs"},   {30'd0, a_fs, b_fs}, 32'd0);
      step(1);
      chk({tag, "_e4_h_a"},  {22'd0, a_h}, 32'd1);
      chk({tag, "_e4_h_b"},  {22'd0, b_h}, 32'd1);
      chk({tag, "_e4_ce"},   {31'd0, a_ce}, 32'd0);
      step(4);
      chk({tag, "_e8_h"},    {22'd0, a_h}, 32'd2);
   endtask

   initial begin
      int a_fall, b_fs_at;
      logic prev_hs;
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      release_seq("rel");

      go_to(316);
      chk("b_vs_line1",  {22'd0, b_v, 1'b0, b_vs}, {22'd0, 10'd1, 2'b00});
      go_to(320);
      chk("b_vs_line2",  {22'd0, b_v, 1'b0, b_vs}, {22'd0, 10'd2, 2'b01});
      go_to(380);
      chk("a_hs_95",     {21'd0, a_h, a_hs}, {21'd0, 10'd95, 1'b0});
      go_to(384);
      chk("a_hs_96",     {21'd0, a_h, a_hs}, {21'd0, 10'd96, 1'b1});
      go_to(676);
      chk("b_win_9_4",   {11'd0, b_h, b_v, b_bright}, {11'd0, 10'd9, 10'd4, 1'b0});
      go_to(680);
      chk("b_win_10_4",  {11'd0, b_h, b_v, b_bright}, {11'd0, 10'd10, 10'd4, 1'b1});
      go_to(2852);
      chk("b_win_33_17", {11'd0, b_h, b_v, b_bright}, {11'd0, 10'd33, 10'd17, 1'b1});
      go_to(2856);
      chk("b_win_34_17", {11'd0, b_h, b_v, b_bright}, {11'd0, 10'd34, 10'd17, 1'b0});
      go_to(2920);
      chk("b_win_10_18", {11'd0, b_h, b_v, b_bright}, {11'd0, 10'd10, 10'd18, 1'b0});
      go_to(3196);
      chk("a_line_end",  {11'd0, a_h, a_v, a_hs}, {11'd0, 10'd799, 10'd0, 1'b1});
      go_to(3199);
      chk("b_frame_end", {11'd0, b_h, b_v, b_fs}, {11'd0, 10'd39, 10'd19, 1'b0});
      go_to(3200);
      chk("a_line_wrap", {11'd0, a_h, a_v, a_hs}, {11'd0, 10'd0, 10'd1, 1'b0});
      chk("b_frame_wrap", {10'd0, b_h, b_v, b_fs, b_vs}, {10'd0, 10'd0, 10'd0, 1'b1, 1'b0});
      go_to(3201);
      chk("b_fs_1clk",   {31'd0, b_fs}, 32'd0);

      a_fall  = -1;
      b_fs_at = -1;
      prev_hs = a_hs;
      for (int i = 0; i < 3500 && (a_fall < 0 || b_fs_at < 0); i++) begin
         step(1);
         if (a_fall < 0 && prev_hs && !a_hs) a_fall = cyc;
         if (b_fs_at < 0 && b_fs) b_fs_at = cyc;
         prev_hs = a_hs;
      end
      chk("a_hs_period", a_fall,  32'd6400);
      chk("b_fs_period", b_fs_at, 32'd6400);

      go_to(8080);
      chk("b_mid_pos", {12'd0, b_h, b_v}, {12'd0, 10'd20, 10'd10});
      #2 rst_n = 1'b0;
      #1 chk_zero("async_rst");
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_zero("async_hold");
      release_seq("rel2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
